// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    localparam int unsigned OCC_W     = 2;
    localparam logic [1:0]  OCC_EMPTY = 2'd0;
    localparam logic [1:0]  OCC_ONE   = 2'd1;
    localparam logic [1:0]  OCC_TWO   = 2'd2;

    // fetch -> decode
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fd_payload_t;

    // decode -> execute
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
    } de_payload_t;

    // execute -> memory
    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
    } em_payload_t;

    // memory -> writeback
    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        wb_en;
    } mw_payload_t;

    localparam int unsigned FD_W = $bits(fd_payload_t);
    localparam int unsigned DE_W = $bits(de_payload_t);
    localparam int unsigned EM_W = $bits(em_payload_t);
    localparam int unsigned MW_W = $bits(mw_payload_t);

    // Number of held entries for a given state.
    function automatic logic [1:0] occ_of(pipe_state_t s);
        logic [1:0] occ;
        occ = OCC_EMPTY;
        case (s)
            PS_ONE:  occ = OCC_ONE;
            PS_TWO:  occ = OCC_TWO;
            default: occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         nRST,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // Count up on inc, stick at the maximum value.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with optional 2-entry skid buffer,
// synchronous flush, occupancy reporting and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH         = 32,
    parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0,
    parameter int unsigned      SKID          = 1,
    parameter int unsigned      CNT_W         = 16
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t      state, state_n;
    logic [WIDTH-1:0] main_q, main_n;
    logic [WIDTH-1:0] skid_q, skid_n;
    logic             in_xfer;
    logic             out_xfer;

    // With skid the ready is a pure state decode; without it ready looks through to out_ready.
    assign in_ready  = (SKID != 0) ? (state != PS_TWO)
                                   : ((state == PS_EMPTY) || out_ready);
    assign out_valid = (state != PS_EMPTY);
    assign out_data  = main_q;
    assign occupancy = occ_of(state);

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Next state and register loads; flush overrides every handshake.
    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = PS_EMPTY;
            main_n  = RESET_PAYLOAD;
            skid_n  = RESET_PAYLOAD;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (in_xfer) begin
                        state_n = PS_ONE;
                        main_n  = in_data;
                    end
                end
                PS_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_n = in_data;
                    end else if (in_xfer) begin
                        state_n = PS_TWO;
                        skid_n  = in_data;
                    end else if (out_xfer) begin
                        state_n = PS_EMPTY;
                    end
                end
                PS_TWO: begin
                    if (out_xfer) begin
                        state_n = PS_ONE;
                        main_n  = skid_q;
                    end
                end
                default: begin
                    state_n = PS_EMPTY;
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state  <= PS_EMPTY;
            main_q <= RESET_PAYLOAD;
            skid_q <= RESET_PAYLOAD;
        end else begin
            state  <= state_n;
            main_q <= main_n;
            skid_q <= skid_n;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .nRST (nRST),
        .inc  (out_valid && !out_ready),
        .clear(1'b0),
        .count(stall_cnt)
    );

endmodule
